// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for MIPS-style R-type ops.
//   mult/multu: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit product in {hi,lo}
//   div/divu:   restoring shift-subtract, one bit per cycle, lo = quotient, hi = remainder
//   mthi/mtlo:  single-cycle move of a into hi/lo
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    operation request, only honoured while idle
//   funct    R-type function field
//   a, b     rs / rt operands
//   busy     multiply or divide in progress
//   done     one-cycle pulse after HI/LO receive a mul/div result
//   divzero  accompanies done when the divide had b == 0
//   illegal  one-cycle pulse after start with an unsupported funct
//   hi, lo   HI/LO registers
//
// state  | meaning
// IDLE   | waiting for start; handles mthi/mtlo, divide-by-zero, illegal funct
// MUL    | WIDTH shift-add iterations on unsigned magnitudes
// DIV    | WIDTH restoring-divide iterations on unsigned magnitudes
// FIX    | sign correction and HI/LO write, then back to IDLE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  // Multiply: {partial product high, multiplier bits still to consume}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic               op_div;
  logic               neg_res;
  logic               neg_rem;

  logic               is_mul;
  logic               is_div;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  always_comb begin
    is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is its magnitude.
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
  end

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Bit WIDTH set means the trial subtraction went negative: restore.
    div_diff  = div_shift - {1'b0, mag_b};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_div && (b == '0)) begin
              lo      <= '1;
              hi      <= a;
              done    <= 1'b1;
              divzero <= 1'b1;
            end else if (is_mul || is_div) begin
              mag_a   <= abs_a;
              mag_b   <= abs_b;
              acc     <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              cnt     <= '0;
              op_div  <= is_div;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              state   <= is_div ? S_DIV : S_MUL;
            end else if (funct == F_MTHI) begin
              hi <= a;
            end else if (funct == F_MTLO) begin
              lo <= a;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (state == S_MUL) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (op_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, divzero, illegal;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .divzero(divzero), .illegal(illegal),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo} for a completed mul/div.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    u  = '0;
    case (f)
      F_MULT:  begin q = sx * sy; u = q; end
      F_MULTU: u = {32'd0, x} * {32'd0, y};
      F_DIV:   begin q = sx / sy; r = sx % sy; u = {r[31:0], q[31:0]}; end
      F_DIVU:  u = {x % y, x / y};
      default: u = '0;
    endcase
    return u;
  endfunction

  // Transaction-level model: a mul/div is "in flight" for W+1 cycles, then lands.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0, m_ill = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_hi = '0; m_lo = '0;
      m_done = 1'b0; m_dz = 1'b0; m_ill = 1'b0;
    end else begin
      m_done = 1'b0; m_dz = 1'b0; m_ill = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        case (funct)
          F_MULT, F_MULTU: begin
            {p_hi, p_lo} = ref_result(funct, a, b);
            m_left = W + 1;
          end
          F_DIV, F_DIVU: begin
            if (b == 0) begin
              m_hi = a; m_lo = '1; m_done = 1'b1; m_dz = 1'b1;
            end else begin
              {p_hi, p_lo} = ref_result(funct, a, b);
              m_left = W + 1;
            end
          end
          F_MTHI:  m_hi = a;
          F_MTLO:  m_lo = a;
          default: m_ill = 1'b1;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_busy", W'(busy), W'(m_left > 0));
      chk("cyc_done", W'(done), W'(m_done));
      chk("cyc_divzero", W'(divzero), W'(m_dz));
      chk("cyc_illegal", W'(illegal), W'(m_ill));
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int nb, dn;

  initial begin
    #3 reset = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", W'(busy), 32'h0);
    chk("reset_done", W'(done), 32'h0);
    settle(2);
    reset = 1'b1;

    // Model pinned against hand-computed values.
    chk("model_mult", ref_result(F_MULT, 32'hFFFFFFFD, 32'd7) >> 32, 32'hFFFFFFFF);
    chk("model_div_q", ref_result(F_DIV, 32'hFFFFFFF9, 32'd2) & 64'hFFFFFFFF, 32'hFFFFFFFD);
    chk("model_divu_r", ref_result(F_DIVU, 32'd100, 32'd7) >> 32, 32'd2);

    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    nb = 0; dn = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) dn = i;
      @(negedge clk);
    end
    chk("multu_busy_cycles", nb, 33);
    chk("multu_done_pos", dn, 33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    issue(F_MULT, 32'hFFFFFFFD, 32'd7); settle(36);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    issue(F_DIV, 32'hFFFFFFF9, 32'd2); settle(36);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(F_DIVU, 32'h12345678, 32'd0);
    chk("dz_done", W'(done), 32'h1);
    chk("dz_flag", W'(divzero), 32'h1);
    chk("dz_busy", W'(busy), 32'h0);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'h12345678);
    settle(2);

    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF); settle(36);
    chk("minneg_lo", lo, 32'h80000000);
    chk("minneg_hi", hi, 32'h00000000);

    issue(F_DIV, 32'd7, 32'hFFFFFFFE); settle(36);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'h00000001);

    issue(F_DIVU, 32'd100, 32'd7); settle(36);
    chk("divu_lo", lo, 32'h0000000E);
    chk("divu_hi", hi, 32'h00000002);

    issue(F_MULT, 32'h00001234, 32'h00000010);
    settle(4);
    issue(F_MTLO, 32'hDEADBEEF, 32'd0);
    settle(36);
    chk("ignored_mtlo_lo", lo, 32'h00012340);
    chk("ignored_mtlo_hi", hi, 32'h00000000);

    issue(F_MTHI, 32'h11111111, 32'd0);
    issue(F_DIVU, 32'hFFFF0000, 32'd3);
    settle(10);
    reset = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", W'(busy), 32'h0);
    settle(2);
    reset = 1'b1; start = 1'b1; funct = F_MTHI; a = 32'hA5A5A5A5; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_mthi", hi, 32'hA5A5A5A5);
    chk("post_rst_done", W'(done), 32'h0);
    settle(40);

    issue(6'b100000, 32'd1, 32'd2);
    chk("illegal_pulse", W'(illegal), 32'h1);
    chk("illegal_busy", W'(busy), 32'h0);
    chk("illegal_hi", hi, 32'hA5A5A5A5);
    chk("illegal_lo", lo, 32'h0);
    @(negedge clk);
    chk("illegal_one_cycle", W'(illegal), 32'h0);

    issue(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF); settle(36);
    chk("mult_m1_hi", hi, 32'h0);
    chk("mult_m1_lo", lo, 32'h1);

    issue(F_MTLO, 32'hCAFEF00D, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);

    issue(F_DIV, 32'h80000000, 32'd0);
    chk("sdz_lo", lo, 32'hFFFFFFFF);
    chk("sdz_hi", hi, 32'h80000000);
    settle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; legal values are even and at least 4.
REQ-002 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: requests an operation in the cycle it is high.
REQ-005 Port funct, input, 6 bits: R-type function field selecting the operation.
REQ-006 Port a, input, WIDTH bits: rs operand (dividend or multiplicand).
REQ-007 Port b, input, WIDTH bits: rt operand (divisor or multiplier).
REQ-008 Port busy, output, 1 bit: high while a multiply or divide is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when HI/LO receive a multiply or divide result.
REQ-010 Port divzero, output, 1 bit: high together with done when the completed divide had b == 0.
REQ-011 Port illegal, output, 1 bit: one-cycle pulse when start is accepted with an unsupported funct.
REQ-012 Port hi, output, WIDTH bits: current HI register value (serves mfhi).
REQ-013 Port lo, output, WIDTH bits: current LO register value (serves mflo).

Function
REQ-014 Supported funct codes SHALL be: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
REQ-015 start SHALL be accepted only in IDLE; start while busy is high SHALL be ignored, with no effect on state, operands, HI/LO or outputs.
REQ-016 The FSM SHALL have exactly the states IDLE, MUL, DIV and FIX.
REQ-017 IDLE transitions: accepted mult/multu -> MUL; accepted div/divu with b != 0 -> DIV; all other cases stay in IDLE.
REQ-018 On acceptance edge E0 the block SHALL latch the operand magnitudes (absolute values for signed ops, raw values for unsigned ops) and the result sign, and clear the iteration counter.
REQ-019 MUL and DIV SHALL each run for exactly WIDTH edges (E1..E_WIDTH): radix-2 shift-add multiply, restoring shift-subtract divide, one bit per edge; then the FSM goes to FIX.
REQ-020 In FIX the block SHALL apply two's-complement sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-021 FIX SHALL write the result at edge E_(WIDTH+1) and return to IDLE: multiply -> {hi,lo} = 2*WIDTH-bit product; divide -> lo = quotient, hi = remainder.
REQ-022 busy SHALL be high from after E0 through E_(WIDTH+1), i.e. WIDTH+1 cycles.
REQ-023 done SHALL be high for exactly the one cycle following the HI/LO write.
REQ-024 Signed most-negative divided by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-025 div/divu with b == 0 SHALL not enter DIV; at E0 it SHALL write lo = all ones and hi = a; done and divzero SHALL pulse in the next cycle and busy SHALL stay low.
REQ-026 mthi/mtlo accepted at E0 SHALL write a into hi/lo respectively; busy and done SHALL stay low.
REQ-027 Unsupported funct with start in IDLE SHALL pulse illegal in the cycle after E0 and SHALL leave HI/LO unchanged.
REQ-028 HI/LO SHALL change only on the writes in REQ-021, REQ-025 and REQ-026, and on reset.

Reset
REQ-029 While reset is low: state = IDLE, counter, operand registers and hi/lo = 0, and busy, done, divzero, illegal = 0, applied asynchronously.
REQ-030 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL occur after release.
REQ-031 After reset release, the first rising edge SHALL accept a start normally.

Verification (WIDTH = 32)
REQ-032 multu, a = b = 0xFFFFFFFF -> busy for 33 cycles, done in the cycle after, hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-033 mult, a = 0xFFFFFFFD (-3), b = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; div, a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-034 divu, a = 0x12345678, b = 0 -> busy never high, done and divzero high in the cycle after E0, lo = 0xFFFFFFFF, hi = 0x12345678.
REQ-035 Cycle 5 of a running mult, start with funct = mtlo, a = 0xDEADBEEF -> ignored; the final lo equals the product, not 0xDEADBEEF.
REQ-036 Reset pulsed low mid-divu -> hi = lo = 0 and busy = 0 immediately; no done pulse afterwards; mthi with a = 0xA5A5A5A5 on the next edge -> hi = 0xA5A5A5A5, done stays 0.
REQ-037 start with funct = 100000 -> illegal pulses for one cycle; hi, lo and busy unchanged.
